// File: rtl/mips_div_iter.sv
// Iterative 32-bit MIPS DIV/DIVU unit with AXI-Stream style operand and result channels.
// The divisor and dividend channels may arrive on the same edge or separately.
// One restoring radix-2 step runs per cycle on operand magnitudes.
// A final cycle applies sign correction and registers the {quotient, remainder} result.
module mips_div_iter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_axis_divisor_tvalid,
  output logic                  s_axis_divisor_tready,
  input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
  input  logic                  s_axis_dividend_tvalid,
  output logic                  s_axis_dividend_tready,
  input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
  input  logic                  div_signed,
  output logic                  m_axis_dout_tvalid,
  input  logic                  m_axis_dout_tready,
  output logic [2*DATA_W-1:0]   m_axis_dout_tdata
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BUSY, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_fin;
  logic                  r_have_dvs;
  logic                  r_have_dvd;
  logic [2*DATA_W-1:0]   r_dout;

  logic [DATA_W-1:0]     r_dvs;
  logic [DATA_W-1:0]     r_dvd;
  logic                  r_signed;
  logic [DATA_W-1:0]     r_rem;
  logic [DATA_W-1:0]     r_quo;

  logic                  w_dvs_hs;
  logic                  w_dvd_hs;
  logic                  w_enter_busy;
  logic                  w_step;
  logic [DATA_W-1:0]     w_dvs_mag;
  logic [DATA_W-1:0]     w_rem_cur;
  logic [DATA_W-1:0]     w_quo_cur;
  logic [DATA_W:0]       w_rem_sh;
  logic [DATA_W:0]       w_diff;
  logic                  w_ge;
  logic [DATA_W-1:0]     w_rem_nxt;
  logic [DATA_W-1:0]     w_quo_nxt;
  logic                  w_q_neg;
  logic                  w_r_neg;
  logic [2*DATA_W-1:0]   w_result;

  // Magnitude of an operand; in unsigned mode the raw bits are already the magnitude.
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] f_mag(input logic signed [DATA_W-1:0] v,
                                              input logic sgn);
    logic signed [DATA_W-1:0] neg;
    neg = -v;
    if (sgn && (v < 0)) return $unsigned(neg);
    return $unsigned(v);
  endfunction

  // Re-applies a sign to an unsigned magnitude (two's complement negate when neg is set).
  function automatic logic [DATA_W-1:0] f_sign(input logic [DATA_W-1:0] mag, input logic neg);
    logic signed [DATA_W-1:0] s;
    s = $signed(mag);
    if (neg) return $unsigned(-s);
    return mag;
  endfunction

  assign w_dvs_hs     = s_axis_divisor_tvalid  & s_axis_divisor_tready;
  assign w_dvd_hs     = s_axis_dividend_tvalid & s_axis_dividend_tready;
  assign w_enter_busy = (w_state_nxt == S_BUSY) && (r_state != S_BUSY);
  assign w_step       = (r_state == S_BUSY) && !r_fin;

  // Restoring step: on the first iteration the working registers still hold stale data,
  // so the partial remainder starts at zero and the shifter starts at |dividend|.
  assign w_dvs_mag = f_mag(r_dvs, r_signed);
  assign w_rem_cur = (r_cnt == '0) ? '0 : r_rem;
  assign w_quo_cur = (r_cnt == '0) ? f_mag(r_dvd, r_signed) : r_quo;
  assign w_rem_sh  = {w_rem_cur, w_quo_cur[DATA_W-1]};
  assign w_diff    = w_rem_sh - {1'b0, w_dvs_mag};
  // The partial remainder stays below the divisor, so a clear top bit means "fits".
  assign w_ge      = ~w_diff[DATA_W];
  assign w_rem_nxt = w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
  assign w_quo_nxt = {w_quo_cur[DATA_W-2:0], w_ge};

  // Quotient is negative when the operand signs differ; remainder follows the dividend.
  // Division by zero bypasses the datapath with the architected all-ones/dividend result.
  assign w_q_neg  = r_signed & (r_dvd[DATA_W-1] ^ r_dvs[DATA_W-1]);
  assign w_r_neg  = r_signed & r_dvd[DATA_W-1];
  assign w_result = (r_dvs == '0) ? {{DATA_W{1'b1}}, r_dvd}
                                  : {f_sign(r_quo, w_q_neg), f_sign(r_rem, w_r_neg)};

  assign m_axis_dout_tdata = r_dout;

  // State register plus control counters and the result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_fin      <= 1'b0;
      r_have_dvs <= 1'b0;
      r_have_dvd <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_dvs_hs) r_have_dvs <= 1'b1;
      if (w_dvd_hs) r_have_dvd <= 1'b1;
      if (w_enter_busy) begin
        r_have_dvs <= 1'b0;
        r_have_dvd <= 1'b0;
        r_cnt      <= '0;
        r_fin      <= 1'b0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) r_fin <= 1'b1;
      end else if ((r_state == S_BUSY) && r_fin) begin
        r_dout <= w_result;
        r_fin  <= 1'b0;
      end
    end
  end

  // Operand capture on handshakes and the per-cycle division step (no reset needed).
  always_ff @(posedge clk) begin
    if (w_dvs_hs) r_dvs <= s_axis_divisor_tdata;
    if (w_dvd_hs) begin
      r_dvd    <= s_axis_dividend_tdata;
      r_signed <= div_signed;
    end
    if (w_step) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_dvs_hs && w_dvd_hs)      w_state_nxt = S_BUSY;
        else if (w_dvs_hs || w_dvd_hs) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if ((r_have_dvs || w_dvs_hs) && (r_have_dvd || w_dvd_hs)) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (r_fin) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (m_axis_dout_tready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs: in WAIT only the channel still missing its operand is ready.
  always_comb begin
    s_axis_divisor_tready  = 1'b0;
    s_axis_dividend_tready = 1'b0;
    m_axis_dout_tvalid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        s_axis_divisor_tready  = 1'b1;
        s_axis_dividend_tready = 1'b1;
      end
      S_WAIT: begin
        s_axis_divisor_tready  = ~r_have_dvs;
        s_axis_dividend_tready = ~r_have_dvd;
      end
      S_DONE: m_axis_dout_tvalid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_div_iter.sv
// Self-checking bench for mips_div_iter: vector table through a result scoreboard,
// plus hand-written sequences for split operand arrival, output backpressure and reset abort.
module tb_mips_div_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_axis_divisor_tvalid;
  logic        s_axis_divisor_tready;
  logic [31:0] s_axis_divisor_tdata;
  logic        s_axis_dividend_tvalid;
  logic        s_axis_dividend_tready;
  logic [31:0] s_axis_dividend_tdata;
  logic        div_signed;
  logic        m_axis_dout_tvalid;
  logic        m_axis_dout_tready;
  logic [63:0] m_axis_dout_tdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    logic [31:0] dvs;
    logic [31:0] dvd;
    logic        sgn;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[13];

  mips_div_iter dut (
    .clk                    (clk),
    .reset                  (reset),
    .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
    .s_axis_divisor_tready  (s_axis_divisor_tready),
    .s_axis_divisor_tdata   (s_axis_divisor_tdata),
    .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
    .s_axis_dividend_tready (s_axis_dividend_tready),
    .s_axis_dividend_tdata  (s_axis_dividend_tdata),
    .div_signed             (div_signed),
    .m_axis_dout_tvalid     (m_axis_dout_tvalid),
    .m_axis_dout_tready     (m_axis_dout_tready),
    .m_axis_dout_tdata      (m_axis_dout_tdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: a result is consumed on the edge after a negedge that sees valid & ready.
  always begin
    @(negedge clk);
    #1;
    if (!reset && m_axis_dout_tvalid && m_axis_dout_tready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dout_unexpected: got %h with empty scoreboard", m_axis_dout_tdata);
      end else begin
        chk("dout", m_axis_dout_tdata, sb_q.pop_front());
      end
    end
  end

  task automatic wait_tvalid(input int exp_lat, input string name);
    int lat = 0;
    while (!m_axis_dout_tvalid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(name, 64'(lat), 64'(exp_lat));
  endtask

  task automatic do_op(input logic [31:0] dvs, input logic [31:0] dvd, input logic sgn,
                       input logic [63:0] exp, input string name);
    @(negedge clk);
    sb_q.push_back(exp);
    s_axis_divisor_tvalid  = 1'b1;
    s_axis_divisor_tdata   = dvs;
    s_axis_dividend_tvalid = 1'b1;
    s_axis_dividend_tdata  = dvd;
    div_signed             = sgn;
    @(posedge clk);
    #1;
    s_axis_divisor_tvalid  = 1'b0;
    s_axis_dividend_tvalid = 1'b0;
    chk({name, "_busy_rdy"}, {s_axis_divisor_tready, s_axis_dividend_tready}, 64'd0);
    wait_tvalid(33, {name, "_lat"});
    @(posedge clk);
    #1;
    chk({name, "_idle"}, m_axis_dout_tvalid, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'd7,        32'd100,      1'b0, 64'h0000000E_00000002};
    vecs[1]  = '{32'd2,        32'hFFFFFFF9, 1'b1, 64'hFFFFFFFD_FFFFFFFF};
    vecs[2]  = '{32'hFFFFFFFE, 32'd7,        1'b1, 64'hFFFFFFFD_00000001};
    vecs[3]  = '{32'hFFFFFFFF, 32'h80000000, 1'b1, 64'h80000000_00000000};
    vecs[4]  = '{32'hFFFFFFFF, 32'h80000000, 1'b0, 64'h00000000_80000000};
    vecs[5]  = '{32'd0,        32'd5,        1'b0, 64'hFFFFFFFF_00000005};
    vecs[6]  = '{32'd0,        32'hFFFFFFF9, 1'b1, 64'hFFFFFFFF_FFFFFFF9};
    vecs[7]  = '{32'hFFFFFFFE, 32'hFFFFFFF9, 1'b1, 64'h00000003_FFFFFFFF};
    vecs[8]  = '{32'hFFFFFFFE, 32'hFFFFFFF9, 1'b0, 64'h00000000_FFFFFFF9};
    vecs[9]  = '{32'd1,        32'hDEADBEEF, 1'b0, 64'hDEADBEEF_00000000};
    vecs[10] = '{32'h10,       32'hFFFFFFFF, 1'b0, 64'h0FFFFFFF_0000000F};
    vecs[11] = '{32'd3,        32'h7FFFFFFF, 1'b1, 64'h2AAAAAAA_00000001};
    vecs[12] = '{32'd2,        32'hFFFFFFF9, 1'b0, 64'h7FFFFFFC_00000001};

    reset                  = 1'b1;
    s_axis_divisor_tvalid  = 1'b0;
    s_axis_divisor_tdata   = '0;
    s_axis_dividend_tvalid = 1'b0;
    s_axis_dividend_tdata  = '0;
    div_signed             = 1'b0;
    m_axis_dout_tready     = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_dout_tvalid, 64'd0);
    chk("rst_tdata", m_axis_dout_tdata, 64'd0);
    chk("rst_treadys", {s_axis_divisor_tready, s_axis_dividend_tready}, 64'd3);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors, both channels on the same edge
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].dvs, vecs[i].dvd, vecs[i].sgn, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Divisor first, dividend three edges later; stale divisor valid must be ignored in WAIT
    @(negedge clk);
    sb_q.push_back(64'h00000006_00000002);
    s_axis_divisor_tvalid  = 1'b1;
    s_axis_divisor_tdata   = 32'd3;
    s_axis_dividend_tvalid = 1'b0;
    div_signed             = 1'b0;
    @(posedge clk);
    #1;
    s_axis_divisor_tdata = 32'h12345678;
    for (int e = 0; e < 3; e++) begin
      chk($sformatf("wait_dvs_rdy%0d", e), s_axis_divisor_tready, 64'd0);
      chk($sformatf("wait_dvd_rdy%0d", e), s_axis_dividend_tready, 64'd1);
      if (e == 2) begin
        s_axis_dividend_tvalid = 1'b1;
        s_axis_dividend_tdata  = 32'd20;
      end
      @(posedge clk);
      #1;
    end
    s_axis_divisor_tvalid  = 1'b0;
    s_axis_dividend_tvalid = 1'b0;
    chk("wait_busy_rdy", {s_axis_divisor_tready, s_axis_dividend_tready}, 64'd0);
    wait_tvalid(33, "wait_lat");
    @(posedge clk);
    #1;
    chk("wait_idle", m_axis_dout_tvalid, 64'd0);

    // Backpressure in DONE, with junk operands offered during BUSY and DONE
    m_axis_dout_tready = 1'b0;
    @(negedge clk);
    sb_q.push_back(64'hFFFFFFFD_FFFFFFFF);
    s_axis_divisor_tvalid  = 1'b1;
    s_axis_divisor_tdata   = 32'd2;
    s_axis_dividend_tvalid = 1'b1;
    s_axis_dividend_tdata  = 32'hFFFFFFF9;
    div_signed             = 1'b1;
    @(posedge clk);
    #1;
    s_axis_divisor_tdata  = 32'd9;
    s_axis_dividend_tdata = 32'd1000;
    div_signed            = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("busy_ign_rdy%0d", c), {s_axis_divisor_tready, s_axis_dividend_tready}, 64'd0);
      @(posedge clk);
      #1;
    end
    s_axis_divisor_tvalid  = 1'b0;
    s_axis_dividend_tvalid = 1'b0;
    wait_tvalid(30, "bp_lat");
    s_axis_divisor_tvalid  = 1'b1;
    s_axis_dividend_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_tvalid%0d", c), m_axis_dout_tvalid, 64'd1);
      chk($sformatf("bp_tdata%0d", c), m_axis_dout_tdata, 64'hFFFFFFFD_FFFFFFFF);
      chk($sformatf("bp_rdy%0d", c), {s_axis_divisor_tready, s_axis_dividend_tready}, 64'd0);
      @(posedge clk);
      #1;
    end
    s_axis_divisor_tvalid  = 1'b0;
    s_axis_dividend_tvalid = 1'b0;
    @(negedge clk);
    m_axis_dout_tready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_tvalid", m_axis_dout_tvalid, 64'd0);
    chk("bp_idle_rdy", {s_axis_divisor_tready, s_axis_dividend_tready}, 64'd3);

    // Reset abort around iteration 10, then a fresh operation
    @(negedge clk);
    s_axis_divisor_tvalid  = 1'b1;
    s_axis_divisor_tdata   = 32'd7;
    s_axis_dividend_tvalid = 1'b1;
    s_axis_dividend_tdata  = 32'd100;
    div_signed             = 1'b0;
    @(posedge clk);
    #1;
    s_axis_divisor_tvalid  = 1'b0;
    s_axis_dividend_tvalid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_tvalid", m_axis_dout_tvalid, 64'd0);
    chk("abort_tdata", m_axis_dout_tdata, 64'd0);
    chk("abort_rdy", {s_axis_divisor_tready, s_axis_dividend_tready}, 64'd3);
    @(posedge clk);
    #1;
    chk("abort_hold_tvalid", m_axis_dout_tvalid, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(32'd3, 32'd9, 1'b0, 64'h00000003_00000000, "post_rst");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
